// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS decode-stage register file.
package mips_pkg;
  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int NREGS    = 32;
  localparam int REG_ZERO = 0;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;
endpackage

// File: rtl/mips_regfile_rdport.sv
// One read port: forces register 0 to zero, bypasses same-cycle writeback
// data, and masks the busy flag while that register is being released.
module mips_regfile_rdport #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_busy,
  input  logic          wr_en,
  input  logic          wr_release,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_busy
);
  import mips_pkg::*;

  logic is_zero;
  logic hit;

  always_comb begin
    is_zero = (rd_addr == AW'(REG_ZERO));
    hit     = wr_en && (wr_addr == rd_addr);
    if (is_zero)
      rd_data = '0;
    else if (hit)
      rd_data = wr_data;
    else
      rd_data = mem_data;
    rd_busy = !is_zero && mem_busy && !(hit && wr_release);
  end
endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file with write-to-read bypass, hard-wired zero register and
// a per-register pending-write scoreboard with registered pending count.
module mips_regfile_sb #(
  parameter int DW     = mips_pkg::DW,
  parameter int NREGS  = mips_pkg::NREGS,
  parameter int AW     = mips_pkg::AW,
  parameter int NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 wr_release,
  input  logic                 resv_en,
  input  logic [AW-1:0]        resv_addr,
  output logic [AW:0]          pend_cnt,
  output logic                 any_pend
);
  import mips_pkg::*;

  logic [DW-1:0]    mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Set is applied after clear so a new reservation supersedes a release.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (wr_en && wr_release && (wr_addr == AW'(r))) busy_nxt[r] = 1'b0;
      if (resv_en && (resv_addr == AW'(r)))          busy_nxt[r] = 1'b1;
    end
    busy_nxt[REG_ZERO] = 1'b0;
    for (int r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  assign any_pend = (pend_cnt != '0);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[i*AW +: AW];

    mips_regfile_rdport #(.DW(DW), .AW(AW)) u_rdport (
      .rd_addr    (addr),
      .mem_data   (mem[addr]),
      .mem_busy   (busy[addr]),
      .wr_en      (wr_en),
      .wr_release (wr_release),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data[i*DW +: DW]),
      .rd_busy    (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed and random checks of mips_regfile_sb against an array-based model.
module tb_mips_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_release = 1'b0;
  logic        resv_en = 1'b0;
  logic [4:0]  resv_addr = '0;
  logic [5:0]  pend_cnt;
  logic        any_pend;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  mips_regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_release(wr_release), .resv_en(resv_en), .resv_addr(resv_addr),
    .pend_cnt(pend_cnt), .any_pend(any_pend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pend();
    int n = 0;
    for (int r = 0; r < 32; r++) if (m_busy[r]) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(wr_en && wr_release && wr_addr == a);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_release = 0; resv_en = 0;
  endtask

  // Inputs are set by the caller just after a negedge.
  task automatic cycle(input string tag);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s rd_data%0d", tag, p), 64'(rd_data[p*32 +: 32]),
          64'(exp_data(rd_addr[p*5 +: 5])));
      chk($sformatf("%s rd_busy%0d", tag, p), 64'(rd_busy[p]),
          64'(exp_busy(rd_addr[p*5 +: 5])));
    end
    @(posedge clk);
    if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
    if (wr_en && wr_release) m_busy[wr_addr] = 1'b0;
    if (resv_en && resv_addr != 0) m_busy[resv_addr] = 1'b1;
    #1;
    chk({tag, " pend_cnt"}, 64'(pend_cnt), 64'(model_pend()));
    chk({tag, " any_pend"}, 64'(any_pend), 64'(model_pend() != 0));
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset rd_data", 64'(rd_data), 64'h0);
    chk("reset pend_cnt", 64'(pend_cnt), 64'h0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // write / read / zero register
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr = {5'd1, 5'd2};
    cycle("wr r5");
    idle(); rd_addr = {5'd5, 5'd5};
    cycle("rd r5");
    chk("r5 value", 64'(rd_data), {32'hDEADBEEF, 32'hDEADBEEF});
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    cycle("wr r0");
    idle(); rd_addr = {5'd5, 5'd0};
    cycle("rd r0");

    // bypass
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h55AA55AA; rd_addr = {5'd5, 5'd7};
    #1 chk("bypass r7", 64'(rd_data[31:0]), 64'h55AA55AA); #(-0);
    cycle("bypass");

    // scoreboard reserve / release
    idle(); resv_en = 1; resv_addr = 9; rd_addr = {5'd9, 5'd9};
    cycle("resv r9");
    idle(); rd_addr = {5'd0, 5'd9};
    cycle("busy r9");
    idle(); wr_en = 1; wr_release = 1; wr_addr = 9; wr_data = 32'hCAFE0009;
    rd_addr = {5'd9, 5'd9};
    cycle("release r9");

    // collision: reserve and release the same register in one cycle
    idle(); resv_en = 1; resv_addr = 3;
    cycle("resv r3");
    idle(); resv_en = 1; resv_addr = 3; wr_en = 1; wr_release = 1; wr_addr = 3;
    wr_data = 32'h33333333; rd_addr = {5'd3, 5'd3};
    cycle("collide r3");
    idle(); rd_addr = {5'd3, 5'd3};
    cycle("after collide");
    chk("collide busy", 64'(rd_busy), 64'h3);

    // fill the scoreboard
    for (int r = 1; r < 32; r++) begin
      idle(); resv_en = 1; resv_addr = 5'(r); rd_addr = {5'(r), 5'(32 - r)};
      cycle("fill");
    end
    chk("fill full", 64'(pend_cnt), 64'd31);
    idle(); resv_en = 1; resv_addr = 0;
    cycle("resv r0");
    for (int r = 1; r < 32; r++) begin
      idle(); wr_en = 1; wr_release = 1; wr_addr = 5'(r); wr_data = $urandom;
      rd_addr = {5'(r), 5'((r + 1) % 32)};
      cycle("drain");
    end
    chk("drain empty", 64'(pend_cnt), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_release = ($urandom_range(0, 1) == 1);
      wr_addr    = 5'($urandom);
      wr_data    = $urandom;
      resv_en    = ($urandom_range(0, 2) == 0);
      resv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? rd_addr[4:0] : 5'($urandom);
      cycle("rand");
    end

    // asynchronous reset mid-run with pending state
    idle(); resv_en = 1; resv_addr = 12; wr_en = 1; wr_addr = 12; wr_data = 32'hABCD;
    cycle("pre-reset");
    idle(); rd_addr = {5'd12, 5'd5};
    #2 rst_n = 0;
    #1;
    chk("async rst rd_data", 64'(rd_data), 64'h0);
    chk("async rst rd_busy", 64'(rd_busy), 64'h0);
    chk("async rst pend_cnt", 64'(pend_cnt), 64'h0);
    chk("async rst any_pend", 64'(any_pend), 64'h0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    for (int r = 1; r < 32; r++) begin
      idle(); rd_addr = {5'(32 - r), 5'(r)};
      cycle("post-reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
